// File: rtl/fifo_ctrl_8x16_pkg.sv
// Shared FIFO constants for the 8x16 RAM and its pointer/flag controller.
package fifo_pkg;

  localparam int DEPTH    = 8;
  localparam int ADDR_BUS = 3;
  localparam int WIDTH    = 16;

endpackage

// File: rtl/fifo_ctrl_8x16_if.sv
// Request/RAM-control/status bundle between the FIFO user, the controller and the RAM.
//
// Handshake: wr_en/rd_en are requests held by the master for one cycle each.
// A request is taken on a rising edge only when the matching RAM strobe
// (we for wr_en, re for rd_en) is high in that cycle. A request that is
// not taken is simply dropped and reported one cycle later on
// overflow/underflow. Read data is valid on the RAM dout in the cycle
// where rd_valid is high.
interface fifo_ctrl_8x16_if;
  import fifo_pkg::*;

  logic                wr_en;
  logic                rd_en;
  logic                we;
  logic                re;
  logic [ADDR_BUS-1:0] wr_addr;
  logic [ADDR_BUS-1:0] rd_addr;
  logic                full;
  logic                empty;
  logic [ADDR_BUS:0]   count;
  logic                rd_valid;
  logic                overflow;
  logic                underflow;
  logic                almost_full;
  logic                almost_empty;

  // User side: issues requests and observes strobes and status.
  modport master (
    output wr_en, rd_en,
    input  we, re, wr_addr, rd_addr, full, empty, count,
           rd_valid, overflow, underflow, almost_full, almost_empty
  );

  // Controller side: qualifies requests and drives RAM control and status.
  modport slave (
    input  wr_en, rd_en,
    output we, re, wr_addr, rd_addr, full, empty, count,
           rd_valid, overflow, underflow, almost_full, almost_empty
  );

endinterface

// File: rtl/fifo_ctrl_8x16_ptr.sv
// Binary FIFO pointer, one bit wider than the RAM address so that the
// extra MSB separates the full case from the empty case.
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Advance by one on each accepted access; wraps modulo 2**W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl_8x16.sv
// fifo_ctrl_8x16: turns the 8x16 dual-port RAM (registered read) into a
// synchronous FIFO. Qualifies push/pop requests into RAM we/re, keeps the
// occupancy count and registered full/empty/over/underflow flags, and
// produces rd_valid aligned with the RAM's registered dout.
// Optional feature macro: FIFO_ALMOST_FLAGS_EN enables the registered
// almost_full / almost_empty flags; otherwise both are tied low.
module fifo_ctrl_8x16
  import fifo_pkg::*;
#(
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  fifo_ctrl_8x16_if.slave  bus
);

  localparam int CW = ADDR_BUS + 1;

  // Catch impossible threshold settings at elaboration.
  if (AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
    $error("fifo_ctrl_8x16: AE_LEVEL must be below AF_LEVEL and AF_LEVEL within DEPTH");
  end

  logic          we;
  logic          re;
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;

  // A pop needs data; a push while full only fits if a pop frees the slot
  // in the same cycle (the RAM then returns the old word and stores the new one).
  assign re = bus.rd_en & ~bus.empty;
  assign we = bus.wr_en & (~bus.full | re);

  assign bus.we      = we;
  assign bus.re      = re;
  assign bus.wr_addr = wr_ptr[ADDR_BUS-1:0];
  assign bus.rd_addr = rd_ptr[ADDR_BUS-1:0];

  fifo_ptr #(.W(CW)) u_wr_ptr (.clk(clk), .rst(rst), .inc(we), .ptr(wr_ptr));
  fifo_ptr #(.W(CW)) u_rd_ptr (.clk(clk), .rst(rst), .inc(re), .ptr(rd_ptr));

  // Occupancy after this edge; flags are derived from it so they are registered.
  always_comb begin
    count_nxt = bus.count + CW'(we) - CW'(re);
  end

  // Count, full/empty, read-valid and rejection pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.count     <= '0;
      bus.full      <= 1'b0;
      bus.empty     <= 1'b1;
      bus.rd_valid  <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.count     <= count_nxt;
      bus.full      <= (count_nxt == CW'(DEPTH));
      bus.empty     <= (count_nxt == '0);
      bus.rd_valid  <= re;
      bus.overflow  <= bus.wr_en & ~we;
      bus.underflow <= bus.rd_en & ~re;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  // Threshold flags registered alongside full/empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.almost_full  <= 1'b0;
      bus.almost_empty <= 1'b1;
    end else begin
      bus.almost_full  <= (count_nxt >= CW'(AF_LEVEL));
      bus.almost_empty <= (count_nxt <= CW'(AE_LEVEL));
    end
  end
`else
  assign bus.almost_full  = 1'b0;
  assign bus.almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl_8x16.sv
// Bench for fifo_ctrl_8x16: a behavioural 8x16 RAM with registered read is
// attached to the controller, a reference model predicts strobes and
// flags, and a scoreboard checks read data order.
module tb_fifo_ctrl_8x16;
  import fifo_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fifo_ctrl_8x16_if bus();

  fifo_ctrl_8x16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- RAM under control ----------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_dout;
  logic [WIDTH-1:0] wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ram_dout <= '0;
    end else begin
      if (bus.we) mem[bus.wr_addr] <= wdata;
      if (bus.re) ram_dout <= mem[bus.rd_addr];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int               n_cmp;
  int               n_err;
  int               m_count;
  logic [3:0]       m_wp;
  logic [3:0]       m_rp;
  logic             m_rv;
  logic             m_ov;
  logic             m_un;
  logic             e_we;
  logic             e_re;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_wp    = '0;
    m_rp    = '0;
    m_rv    = 1'b0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_status();
    logic e_af;
    logic e_ae;
`ifdef FIFO_ALMOST_FLAGS_EN
    e_af = (m_count >= 6);
    e_ae = (m_count <= 2);
`else
    e_af = 1'b0;
    e_ae = 1'b0;
`endif
    check("count",        32'(bus.count),        32'(m_count));
    check("full",         32'(bus.full),         32'(m_count == DEPTH));
    check("empty",        32'(bus.empty),        32'(m_count == 0));
    check("rd_valid",     32'(bus.rd_valid),     32'(m_rv));
    check("overflow",     32'(bus.overflow),     32'(m_ov));
    check("underflow",    32'(bus.underflow),    32'(m_un));
    check("almost_full",  32'(bus.almost_full),  32'(e_af));
    check("almost_empty", 32'(bus.almost_empty), 32'(e_ae));
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive requests, check strobes, clock, check flags/data.
  task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
    @(negedge clk);
    bus.wr_en = w;
    bus.rd_en = r;
    wdata     = d;
    #1;
    e_re = r && (m_count != 0);
    e_we = w && ((m_count != DEPTH) || e_re);
    check("we",      32'(bus.we),      32'(e_we));
    check("re",      32'(bus.re),      32'(e_re));
    check("wr_addr", 32'(bus.wr_addr), 32'(m_wp[2:0]));
    check("rd_addr", 32'(bus.rd_addr), 32'(m_rp[2:0]));
    if (e_we) exp_q.push_back(d);
    @(posedge clk);
    #1;
    m_wp    = m_wp + 4'(e_we);
    m_rp    = m_rp + 4'(e_re);
    m_count = m_count + int'(e_we) - int'(e_re);
    m_ov    = w & ~e_we;
    m_un    = r & ~e_re;
    m_rv    = e_re;
    check_status();
    if (m_rv) begin
      if (exp_q.size() == 0) check("sb_underrun", 32'(1), 32'(0));
      else                   check("rd_data", 32'(ram_dout), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    #2;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_status();
    check("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
    check("rst_rd_addr", 32'(bus.rd_addr), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    wdata     = '0;
    model_reset();
    #1;
    check_status();
    check("init_wr_addr", 32'(bus.wr_addr), 32'(0));
    check("init_rd_addr", 32'(bus.rd_addr), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fill, then one rejected push.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, WIDTH'(i));
    cycle(1'b1, 1'b0, 16'h00ff);
    cycle(1'b0, 1'b0, '0);

    // Drain in order, then one rejected pop.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    // Push while empty with a pop in the same cycle: push taken, pop rejected.
    cycle(1'b1, 1'b1, 16'h0a0a);
    cycle(1'b0, 1'b1, '0);

    // Refill, then push+pop together at full, then drain.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, WIDTH'(16'h0010 + i));
    cycle(1'b1, 1'b1, 16'h0beef);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0);

    // Steady occupancy of 3 with wrapping pointers.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, WIDTH'(16'h0200 + i));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, WIDTH'(16'h0300 + i));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 5; i++) cycle(1'b1, i[0], WIDTH'(16'h0400 + i));
    reset_mid_cycle();
    cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, 16'h0555);
    cycle(1'b0, 1'b1, '0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 16'hffff)));
    end
    while (m_count != 0) cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
